// File: rtl/sram_flash_pkg.sv
// Shared definitions for the SRAM/flash bus sequencer.
//   state_t      : sequencer states
//   gnt_t        : which port owns the bus (GNT_CPU / GNT_VID)
//   bus_t        : one registered snapshot of every external bus pin
//   IDLE_BUS     : pin values whenever no access is active (also reset values)
//   FLASH_SEL_BIT: CPU address bit that selects flash over SRAM
//   sram_issue / sram_data / flash_cycle : build the bus snapshot for each phase
package sram_flash_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DATA  = 3'd3,
    F_ACC   = 3'd4,
    ACK     = 3'd5
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VID = 1'b1
  } gnt_t;

  localparam int FLASH_SEL_BIT = 20;

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] dat;
    logic        dat_oe;
    logic        oe_n;
    logic        we_n;
    logic [3:0]  bw_n;
    logic        cen_n;
    logic        adv_ld_n;
    logic        ce2;
  } bus_t;

  localparam bus_t IDLE_BUS = '{
    addr:     21'h0,
    dat:      16'h0,
    dat_oe:   1'b0,
    oe_n:     1'b1,
    we_n:     1'b1,
    bw_n:     4'hF,
    cen_n:    1'b1,
    adv_ld_n: 1'b1,
    ce2:      1'b0
  };

  // ZBT address phase: chip enable + load strobe, byte writes only on writes.
  function automatic bus_t sram_issue(input logic [20:0] addr, input logic we,
                                      input logic [1:0] sel);
    bus_t b;
    b          = IDLE_BUS;
    b.cen_n    = 1'b0;
    b.adv_ld_n = 1'b0;
    b.addr     = addr;
    b.we_n     = ~we;
    b.bw_n     = we ? {2'b11, ~sel} : 4'hF;
    return b;
  endfunction

  // ZBT data phase, two cycles after the address phase.
  function automatic bus_t sram_data(input logic we, input logic [15:0] dat);
    bus_t b;
    b = IDLE_BUS;
    if (we) begin
      b.dat_oe = 1'b1;
      b.dat    = dat;
    end else begin
      b.oe_n = 1'b0;
    end
    return b;
  endfunction

  // One cycle of a wait-stated flash access (address/strobes held throughout).
  function automatic bus_t flash_cycle(input logic [20:0] addr, input logic we,
                                       input logic [15:0] dat);
    bus_t b;
    b      = IDLE_BUS;
    b.ce2  = 1'b1;
    b.addr = addr;
    if (we) begin
      b.we_n   = 1'b0;
      b.dat_oe = 1'b1;
      b.dat    = dat;
    end else begin
      b.oe_n = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/sfa_grant.sv
// Round-robin pick between the CPU and video ports plus the registered
// last_grant it depends on.
//   clk, rst  : clock, synchronous active-high reset
//   cpu_req   : CPU Wishbone request (stb & cyc)
//   vid_req   : video read request
//   take      : the sequencer is in IDLE and will act on the pick this cycle
//   req_any   : at least one port is requesting
//   gnt       : the winning port (only meaningful while req_any)
// Video normally wins; the CPU wins if video had the previous grant, so under
// contention the two ports alternate.
module sfa_grant
  import sram_flash_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic vid_req,
  input  logic take,
  output logic req_any,
  output gnt_t gnt
);

  gnt_t last_grant;

  always_comb begin
    req_any = cpu_req | vid_req;
    gnt     = GNT_CPU;
    if (vid_req && !(last_grant == GNT_VID && cpu_req)) gnt = GNT_VID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_CPU;
    end else if (take && req_any) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/sram_flash_arb.sv
// Sequencer/arbiter for the shared ZBT SRAM + NOR flash bus.
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   cpu_* (Wishbone slave)     : adr[20]=1 flash, else SRAM adr[17:0]; one-cycle ack
//   vid_* (read-only)          : SRAM reads, one-cycle ack
//   sf_* / sram_* / flash_ce2_o: registered board-pin outputs, sf_dat_i input
// Handshake: a port requests by holding its strobe (CPU: stb & cyc) until it
// sees its one-cycle ack; it must drop the strobe in the cycle after the ack.
// Requests are only looked at in IDLE.
// Optional feature macro: FLASH_WRITE_EN enables flash write cycles; without it
// a CPU flash write is acknowledged immediately and the bus stays idle.
// Every bus pin is registered: the next-state logic computes the pin values
// for the coming cycle, so pins line up with the state they belong to.
module sram_flash_arb
  import sram_flash_pkg::*;
#(
  parameter int FLASH_WAIT = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [20:0] cpu_adr_i,
  input  logic [15:0] cpu_dat_i,
  output logic [15:0] cpu_dat_o,
  input  logic [1:0]  cpu_sel_i,
  input  logic        cpu_we_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_cyc_i,
  output logic        cpu_ack_o,
  input  logic [17:0] vid_adr_i,
  input  logic        vid_stb_i,
  output logic [15:0] vid_dat_o,
  output logic        vid_ack_o,
  output logic [20:0] sf_addr_o,
  output logic [15:0] sf_dat_o,
  output logic        sf_dat_oe_o,
  input  logic [15:0] sf_dat_i,
  output logic        sf_oe_n_o,
  output logic        sf_we_n_o,
  output logic [3:0]  sram_bw_n_o,
  output logic        sram_cen_n_o,
  output logic        sram_adv_ld_n_o,
  output logic        flash_ce2_o
);

  localparam logic [3:0] FW_LOAD = 4'(FLASH_WAIT - 1);

  state_t      state_q, state_d;
  gnt_t        gnt_q, gnt_d, gnt;
  logic        req_any, take;
  logic [20:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdat_q, wdat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fl_done_q, fl_done_d;
  logic [15:0] fl_dat_q, fl_dat_d;
  bus_t        bus_q, bus_d;
  logic        cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
  logic [15:0] cpu_dat_q, cpu_dat_d, vid_dat_q, vid_dat_d;

  sfa_grant u_grant (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .cpu_req (cpu_stb_i & cpu_cyc_i),
    .vid_req (vid_stb_i),
    .take    (take),
    .req_any (req_any),
    .gnt     (gnt)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    cnt_d     = cnt_q;
    fl_done_d = fl_done_q;
    fl_dat_d  = fl_dat_q;
    bus_d     = IDLE_BUS;
    take      = 1'b0;
    cpu_ack_d = 1'b0;
    vid_ack_d = 1'b0;
    cpu_dat_d = 16'h0;
    vid_dat_d = 16'h0;

    case (state_q)
      IDLE: begin
        take = 1'b1;
        if (req_any) begin
          gnt_d = gnt;
          if (gnt == GNT_VID) begin
            addr_d  = {3'b000, vid_adr_i};
            we_d    = 1'b0;
            sel_d   = 2'b11;
            wdat_d  = 16'h0;
            state_d = S_ISSUE;
            bus_d   = sram_issue({3'b000, vid_adr_i}, 1'b0, 2'b11);
          end else begin
            we_d   = cpu_we_i;
            sel_d  = cpu_sel_i;
            wdat_d = cpu_dat_i;
            if (!cpu_adr_i[FLASH_SEL_BIT]) begin
              addr_d  = {3'b000, cpu_adr_i[17:0]};
              state_d = S_ISSUE;
              bus_d   = sram_issue({3'b000, cpu_adr_i[17:0]}, cpu_we_i, cpu_sel_i);
            end else begin
              addr_d    = cpu_adr_i;
              cnt_d     = FW_LOAD;
              fl_done_d = 1'b0;
`ifdef FLASH_WRITE_EN
              state_d = F_ACC;
              bus_d   = flash_cycle(cpu_adr_i, cpu_we_i, cpu_dat_i);
`else
              if (cpu_we_i) begin
                // Flash writes unsupported: acknowledge at once, bus untouched.
                state_d   = ACK;
                cpu_ack_d = 1'b1;
              end else begin
                state_d = F_ACC;
                bus_d   = flash_cycle(cpu_adr_i, 1'b0, cpu_dat_i);
              end
`endif
            end
          end
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        state_d = S_DATA;
        bus_d   = sram_data(we_q, wdat_q);
      end

      S_DATA: begin
        // Read data is on sf_dat_i during this cycle; it lands in the ack register.
        state_d = ACK;
        if (gnt_q == GNT_VID) begin
          vid_ack_d = 1'b1;
          vid_dat_d = sf_dat_i;
        end else begin
          cpu_ack_d = 1'b1;
          cpu_dat_d = we_q ? 16'h0 : sf_dat_i;
        end
      end

      F_ACC: begin
        // Strobes are held while the count runs down; data is sampled in the
        // cycle the count is 0, followed by one bus-idle cycle before the ack.
        if (!fl_done_q) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            bus_d = flash_cycle(addr_q, we_q, wdat_q);
          end else begin
            fl_done_d = 1'b1;
            fl_dat_d  = we_q ? 16'h0 : sf_dat_i;
          end
        end else begin
          state_d   = ACK;
          cpu_ack_d = 1'b1;
          cpu_dat_d = fl_dat_q;
        end
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_CPU;
      addr_q    <= 21'h0;
      we_q      <= 1'b0;
      sel_q     <= 2'b00;
      wdat_q    <= 16'h0;
      cnt_q     <= 4'd0;
      fl_done_q <= 1'b0;
      fl_dat_q  <= 16'h0;
      bus_q     <= IDLE_BUS;
      cpu_ack_q <= 1'b0;
      vid_ack_q <= 1'b0;
      cpu_dat_q <= 16'h0;
      vid_dat_q <= 16'h0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      cnt_q     <= cnt_d;
      fl_done_q <= fl_done_d;
      fl_dat_q  <= fl_dat_d;
      bus_q     <= bus_d;
      cpu_ack_q <= cpu_ack_d;
      vid_ack_q <= vid_ack_d;
      cpu_dat_q <= cpu_dat_d;
      vid_dat_q <= vid_dat_d;
    end
  end

  assign sf_addr_o       = bus_q.addr;
  assign sf_dat_o        = bus_q.dat;
  assign sf_dat_oe_o     = bus_q.dat_oe;
  assign sf_oe_n_o       = bus_q.oe_n;
  assign sf_we_n_o       = bus_q.we_n;
  assign sram_bw_n_o     = bus_q.bw_n;
  assign sram_cen_n_o    = bus_q.cen_n;
  assign sram_adv_ld_n_o = bus_q.adv_ld_n;
  assign flash_ce2_o     = bus_q.ce2;
  assign cpu_ack_o       = cpu_ack_q;
  assign vid_ack_o       = vid_ack_q;
  assign cpu_dat_o       = cpu_dat_q;
  assign vid_dat_o       = vid_dat_q;

endmodule

// File: doc/sram_flash_arb.md
# sram_flash_arb

Sequencer and arbiter for the board's shared SRAM/flash bus on the ML403 build (ZBT pipelined SRAM plus parallel NOR flash on one address/data bus). It grants the bus to either the CPU Wishbone port or the video read port, then drives the ZBT protocol (address phase, two-cycle pipeline, data phase) or a wait-stated flash cycle. It sits between the SoC top and the board pins, so all external bus signals are registered here.

## Interface
Parameters:
- FLASH_WAIT, 8: cycles flash address/OE are held before data capture; legal range 2–15.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- cpu_adr_i  in  21  word address; bit 20 = 1 selects flash, 0 selects SRAM using bits 17:0.
- cpu_dat_i  in  16  write data.
- cpu_dat_o  out  16  read data; valid while cpu_ack_o = 1.
- cpu_sel_i  in  2  byte lane enables.
- cpu_we_i  in  1  write strobe qualifier.
- cpu_stb_i, cpu_cyc_i  in  1 each  Wishbone request; a request requires both high.
- cpu_ack_o  out  1  one-cycle acknowledge.
- vid_adr_i  in  18  SRAM word address for the read-only video port.
- vid_stb_i  in  1  video read request.
- vid_dat_o  out  16  video read data; valid while vid_ack_o = 1.
- vid_ack_o  out  1  one-cycle acknowledge.
- sf_addr_o  out  21  shared bus address.
- sf_dat_o  out  16  shared bus write data.
- sf_dat_oe_o  out  1  tristate enable for sf_dat_o.
- sf_dat_i  in  16  shared bus read data.
- sf_oe_n_o, sf_we_n_o  out  1 each  active-low output and write enables.
- sram_bw_n_o  out  4  active-low byte writes; bits 3:2 are always 1.
- sram_cen_n_o  out  1  ZBT chip enable, active low.
- sram_adv_ld_n_o  out  1  ZBT load-address strobe, active low.
- flash_ce2_o  out  1  flash chip enable, active high.

## Operation
- FSM states: IDLE, S_ISSUE, S_WAIT, S_DATA, F_ACC, ACK.
- Requests are sampled only in IDLE. Grant is registered on the IDLE→S_ISSUE or IDLE→F_ACC edge.
- Arbitration:
  - Video has priority.
  - Exception: if the previous grant was video and the CPU is requesting, the CPU wins. This gives round-robin under contention.
  - last_grant resets to CPU.
- SRAM path (CPU with adr[20] = 0, or video):
  - S_ISSUE: cen_n = 0, adv_ld_n = 0, addr driven, we_n = ~we, bw_n[1:0] = ~sel on writes, 2'b11 on reads.
  - S_WAIT: cen_n = 1, bus otherwise idle.
  - S_DATA: on a read, oe_n = 0 and sf_dat_i is captured at the end of the cycle; on a write, sf_dat_oe_o = 1 with the data held.
  - ACK: the granted port's ack = 1 with the captured data; then return to IDLE.
- Flash path (CPU with adr[20] = 1):
  - F_ACC: flash_ce2 = 1, addr driven, oe_n = 0 on reads.
  - A 4-bit down-counter is loaded with FLASH_WAIT − 1. Data is captured in the cycle the count reaches 0, then go to ACK.
- Outside the active states above, all bus outputs are at idle values. The bus is never driven in IDLE or ACK, giving at least one turnaround cycle between accesses.
- Idle/reset values: sf_addr_o = 0, sf_dat_o = 0, sf_dat_oe_o = 0, sf_oe_n_o = 1, sf_we_n_o = 1, sram_bw_n_o = 4'hF, sram_cen_n_o = 1, sram_adv_ld_n_o = 1, flash_ce2_o = 0, both acks 0, both dat_o = 0.
- Reset mid-access: the FSM goes to IDLE at the next edge, no ack is issued, and the access is abandoned.

## Timing
- Latency is counted from the first cycle a request is visible in IDLE (cycle 0).
- SRAM read or write: ack in cycle 4.
- Flash read: ack in cycle FLASH_WAIT + 2.
- Acks are exactly one cycle. The master must drop stb the cycle after ack; IDLE in cycle 5 sees the new request state.
- Maximum throughput: one SRAM access per 5 cycles.
- Worst-case wait for the CPU under continuous video load: one video access.

## Configuration
- FLASH_WRITE_EN defined: flash writes run F_ACC with sf_we_n_o = 0 and sf_dat_oe_o = 1 for FLASH_WAIT cycles, then ack.
- FLASH_WRITE_EN undefined: a CPU write with adr[20] = 1 goes IDLE→ACK, acks in cycle 1, and the bus stays idle.

## Structure
- Package sram_flash_pkg holds:
  - the state enum;
  - the idle bus constants;
  - the FLASH_SEL_BIT = 20 constant;
  - the grant encoding (GNT_CPU, GNT_VID).
- Sub-module sfa_grant: combinational round-robin pick plus the registered last_grant. The main FSM and counter stay in sram_flash_arb.

## Test plan
- CPU SRAM write adr = 0x00123, dat = 0xBEEF, sel = 2'b01:
  - cycle 1: cen_n = 0, adv_ld_n = 0, we_n = 0, bw_n = 4'hE;
  - cycle 3: sf_dat_oe_o = 1, data 0xBEEF;
  - cycle 4: cpu_ack_o.
- Video read adr = 0x00123 with the ZBT model preloaded with 0x1234 → oe_n = 0 in cycle 3, vid_dat_o = 0x1234 with vid_ack_o in cycle 4.
- CPU and video requesting continuously from reset → grants alternate VID, CPU, VID, CPU. The first grant is VID because last_grant resets to CPU.
- Flash read adr = 0x100010 with FLASH_WAIT = 8 → flash_ce2 = 1 for 8 cycles, ack in cycle 10, data matches the flash stub.
- wb_rst_i asserted in S_WAIT of a CPU read → next cycle all outputs at idle values and no ack ever issued.
- CPU flash write: without FLASH_WRITE_EN, ack in cycle 1 and the bus stays idle; with it, sf_we_n_o = 0 for 8 cycles and ack in cycle 10.
